// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package seg_scan_pkg;
  localparam int   MAX_DIGITS = 8;
  localparam logic AN_OFF     = 1'b1;
  localparam logic SEG_OFF    = 1'b1;

  // Active-low one-hot anode pattern; indices at or beyond n leave every anode off.
  function automatic logic [MAX_DIGITS-1:0] onehot_low(input logic [2:0] idx, input int n);
    logic [MAX_DIGITS-1:0] r;
    r = {MAX_DIGITS{AN_OFF}};
    if (int'(idx) < n) r[idx] = ~AN_OFF;
    return r;
  endfunction
endpackage

// File: rtl/seg_scan_tick_gen.sv
// Slot timer: counts 0..COUNT_PERIOD-1 and flags the last count as the wrap strobe.
module scan_tick_gen
  import seg_scan_pkg::*;
#(
  parameter int COUNT_PERIOD = 100000,
  parameter int TW           = $clog2(COUNT_PERIOD)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [TW-1:0] tick_o,
  output logic          wrap_o
);
  logic [TW-1:0] tick_q, tick_d;

  assign wrap_o = (tick_q == TW'(COUNT_PERIOD - 1));
  assign tick_d = wrap_o ? '0 : tick_q + TW'(1);
  assign tick_o = tick_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tick_q <= '0;
    else       tick_q <= tick_d;
  end
endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan controller: shadow capture, digit stepping,
// dead-time, leading-zero blanking and registered anode/dp/nibble outputs.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter  int NUM_DIGITS   = 8,
  parameter  int COUNT_PERIOD = 100000,
  parameter  int DEAD_CYCLES  = 16,
  localparam int IW           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [4*NUM_DIGITS-1:0]   val_in,
  input  logic                      load_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_zeros_in,
  output logic [3:0]                nibble_out,
  output logic [NUM_DIGITS-1:0]     an_out,
  output logic                      dp_out,
  output logic [IW-1:0]             digit_idx_out
);
  localparam int            TW     = $clog2(COUNT_PERIOD);
  localparam logic [TW-1:0] DEAD_T = TW'(DEAD_CYCLES);

  logic [NUM_DIGITS-1:0][3:0] val_sh_q;
  logic [NUM_DIGITS-1:0]      dp_sh_q;
  logic [IW-1:0]              idx_q, idx_d;
  logic [TW-1:0]              tick;
  logic                       wrap;

  scan_tick_gen #(.COUNT_PERIOD(COUNT_PERIOD), .TW(TW)) u_tick (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .tick_o (tick),
    .wrap_o (wrap)
  );

  always_comb begin
    idx_d = idx_q;
    if (wrap) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
  end

  // Walk from the top digit down; a digit blanks only if it and everything above it is zero.
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  zeros_above;
  always_comb begin
    zeros_above = 1'b1;
    blank_vec   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeros_above  = zeros_above & (val_sh_q[i] == 4'h0);
      blank_vec[i] = blank_zeros_in && (i != 0) && zeros_above;
    end
  end

  logic                  an_on;
  logic [MAX_DIGITS-1:0] oh_full;
  logic [NUM_DIGITS-1:0] an_d;
  logic                  dp_d;
  always_comb begin
    an_on   = (tick >= DEAD_T) && !blank_vec[idx_q];
    oh_full = onehot_low(3'(idx_q), NUM_DIGITS);
    an_d    = an_on ? oh_full[NUM_DIGITS-1:0] : {NUM_DIGITS{AN_OFF}};
    dp_d    = an_on ? ~dp_sh_q[idx_q] : SEG_OFF;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      val_sh_q      <= '0;
      dp_sh_q       <= '0;
      idx_q         <= '0;
      nibble_out    <= 4'h0;
      digit_idx_out <= '0;
      an_out        <= {NUM_DIGITS{AN_OFF}};
      dp_out        <= SEG_OFF;
    end else begin
      if (load_in) begin
        val_sh_q <= val_in;
        dp_sh_q  <= dp_in;
      end
      idx_q         <= idx_d;
      nibble_out    <= val_sh_q[idx_q];
      digit_idx_out <= idx_q;
      an_out        <= an_d;
      dp_out        <= dp_d;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: a time-based model predicts every output cycle; a monitor compares.
module tb_seg_scan_driver;
  localparam int N    = 4;
  localparam int CP   = 4;
  localparam int DEAD = 1;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [15:0]   val_in = '0;
  logic          load_in = 1'b0;
  logic [3:0]    dp_in = '0;
  logic          blank_zeros_in = 1'b0;
  logic [3:0]    nibble_out;
  logic [3:0]    an_out;
  logic          dp_out;
  logic [1:0]    digit_idx_out;

  seg_scan_driver #(.NUM_DIGITS(N), .COUNT_PERIOD(CP), .DEAD_CYCLES(DEAD)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .val_in         (val_in),
    .load_in        (load_in),
    .dp_in          (dp_in),
    .blank_zeros_in (blank_zeros_in),
    .nibble_out     (nibble_out),
    .an_out         (an_out),
    .dp_out         (dp_out),
    .digit_idx_out  (digit_idx_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0] nib;
    logic [3:0] an;
    logic       dp;
    logic [1:0] idx;
  } exp_t;

  exp_t        q[$];
  int          m;
  logic [15:0] sh;
  logic [3:0]  dsh;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: the slot position is just the edge count since reset divided up by period.
  initial begin
    int   tk, ix;
    logic bl;
    exp_t e;
    forever begin
      @(posedge clk_in);
      if (rst_in) begin
        m = 0; sh = '0; dsh = '0;
        q.delete();
      end else begin
        tk = m % CP;
        ix = (m / CP) % N;
        bl = blank_zeros_in && (ix != 0) && ((sh >> (4 * ix)) == 16'h0);
        e.idx = 2'(ix);
        e.nib = 4'((sh >> (4 * ix)) & 16'hF);
        if (tk < DEAD || bl) begin
          e.an = 4'hF;
          e.dp = 1'b1;
        end else begin
          e.an = ~(4'b0001 << ix);
          e.dp = ~dsh[ix];
        end
        q.push_back(e);
        if (load_in) begin
          sh  = val_in;
          dsh = dp_in;
        end
        m++;
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      chk("one_anode_max", int'($countones(~an_out) <= 1), 1);
      if (rst_in) begin
        chk("rst_an", int'(an_out), 15);
        chk("rst_dp", int'(dp_out), 1);
        chk("rst_nibble", int'(nibble_out), 0);
        chk("rst_idx", int'(digit_idx_out), 0);
      end else if (q.size() > 0) begin
        e = q.pop_front();
        chk("an_out", int'(an_out), int'(e.an));
        chk("dp_out", int'(dp_out), int'(e.dp));
        chk("nibble_out", int'(nibble_out), int'(e.nib));
        chk("digit_idx_out", int'(digit_idx_out), int'(e.idx));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk_in);
    val_in = v; dp_in = d; load_in = 1'b1;
    @(negedge clk_in);
    load_in = 1'b0;
    val_in = 16'($urandom); dp_in = 4'($urandom);
  endtask

  // Return at a negedge where the next edge sees digit d at tick t.
  task automatic wait_slot(input int d, input int t);
    int n = 0;
    @(negedge clk_in);
    while (!((m % CP) == t && ((m / CP) % N) == d) && n < 64) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 64) chk("wait_slot_timeout", n, 0);
  endtask

  task automatic reset_release_and_first_anode();
    int k = 0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    #1 rst_in = 1'b0;
    while (k < 20) begin
      @(posedge clk_in);
      #1 k++;
      if (an_out[0] == 1'b0) break;
    end
    chk("first_anode_edge", k, DEAD + 1);
  endtask

  initial begin
    logic [15:0] masks [5];
    masks[0] = 16'hFFFF; masks[1] = 16'h0FFF; masks[2] = 16'h00FF;
    masks[3] = 16'h000F; masks[4] = 16'h0000;

    // 1: reset and free-run
    reset_release_and_first_anode();
    run(18);
    // 2: plain display with one decimal point
    blank_zeros_in = 1'b0;
    load(16'h1A2F, 4'b0010);
    run(20);
    // 3: leading zeros blanked
    blank_zeros_in = 1'b1;
    load(16'h0050, 4'($urandom));
    run(20);
    // 4: all zero, then drop blanking mid-slot
    load(16'h0000, 4'b0000);
    run(16);
    wait_slot(1, 2);
    blank_zeros_in = 1'b0;
    run(20);
    // 5: back-to-back loads in digit 2's slot
    wait_slot(2, 1);
    val_in = 16'h1234; dp_in = 4'b0100; load_in = 1'b1;
    @(negedge clk_in);
    val_in = 16'h5678; dp_in = 4'b0000;
    @(negedge clk_in);
    load_in = 1'b0; val_in = 16'h0;
    run(16);
    // Randomized soak with biased leading zeros
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in);
      load_in = ($urandom_range(0, 7) == 0);
      val_in  = 16'($urandom) & masks[$urandom_range(0, 4)];
      dp_in   = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank_zeros_in = ~blank_zeros_in;
    end
    load_in = 1'b0;
    // 6: async reset mid-slot of digit 3
    blank_zeros_in = 1'b0;
    load(16'h8421, 4'b1000);
    wait_slot(3, 2);
    #2 rst_in = 1'b1;
    #1 chk("async_rst_an", int'(an_out), 15);
    chk("async_rst_dp", int'(dp_out), 1);
    reset_release_and_first_anode();
    run(20);
    @(negedge clk_in);
    #1 chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
